// File: rtl/lcd_line_writer.sv
// lcd_line_writer
//   Write-only HD44780 driver for the DE2 16x2 LCD. After reset it waits
//   T_PWRUP cycles, sends the init commands 0x38/0x0C/0x01/0x06 once, then
//   loops forever: set DDRAM address 0x80, write 16 characters taken from a
//   snapshot of d000..d015 sampled when the address write begins.
// Ports:
//   CLOCK_50   system clock
//   RESET      asynchronous active-high reset
//   d000..d015 line-1 character codes, columns 0..15
//   LCD_DATA   LCD data bus (always driven, no reads)
//   LCD_RW     constant 0 (write)
//   LCD_RS     0 = command, 1 = data
//   LCD_EN     write strobe
//   line_done  one-cycle pulse after column 15 completes
module lcd_line_writer #(
   parameter int T_PWRUP = 750000,
   parameter int T_SU    = 2,
   parameter int T_EN    = 12,
   parameter int T_HOLD  = 2,
   parameter int T_CMD   = 2500,
   parameter int T_CLR   = 82000
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic [7:0] d000, d001, d002, d003, d004, d005, d006, d007,
   input  logic [7:0] d008, d009, d010, d011, d012, d013, d014, d015,
   inout  wire  [7:0] LCD_DATA,
   output logic       LCD_RW,
   output logic       LCD_RS,
   output logic       LCD_EN,
   output logic       line_done
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAXT = max2(max2(max2(T_PWRUP, T_SU), max2(T_EN, T_HOLD)),
                              max2(T_CMD, T_CLR));
   localparam int CW   = $clog2(MAXT + 1);

   localparam logic [CW-1:0] PWRUP_L = CW'(T_PWRUP - 1);
   localparam logic [CW-1:0] SU_L    = CW'(T_SU - 1);
   localparam logic [CW-1:0] EN_L    = CW'(T_EN - 1);
   localparam logic [CW-1:0] HOLD_L  = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] CMD_L   = CW'(T_CMD - 1);
   localparam logic [CW-1:0] CLR_L   = CW'(T_CLR - 1);

   // sequence states
   localparam logic [1:0] S_PWRUP = 2'd0;
   localparam logic [1:0] S_INIT  = 2'd1;
   localparam logic [1:0] S_ADDR  = 2'd2;
   localparam logic [1:0] S_CHAR  = 2'd3;

   // byte-write phases
   localparam logic [1:0] PH_SETUP  = 2'd0;
   localparam logic [1:0] PH_STROBE = 2'd1;
   localparam logic [1:0] PH_HOLD   = 2'd2;
   localparam logic [1:0] PH_WAIT   = 2'd3;

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h01;
         default: return 8'h06;
      endcase
   endfunction

   logic [1:0]        state, phase;
   logic [CW-1:0]     cnt;
   logic [3:0]        idx;
   logic [15:0][7:0]  din, snap;
   logic [7:0]        data_q;
   logic              rs_q, en_q;
   logic [CW-1:0]     wait_l;

   assign din = {d015, d014, d013, d012, d011, d010, d009, d008,
                 d007, d006, d005, d004, d003, d002, d001, d000};

   // clear-display needs the long post-write wait
   assign wait_l = (!rs_q && data_q == 8'h01) ? CLR_L : CMD_L;

   assign LCD_DATA = data_q;
   assign LCD_RS   = rs_q;
   assign LCD_EN   = en_q;
   assign LCD_RW   = 1'b0;

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state     <= S_PWRUP;
         phase     <= PH_SETUP;
         cnt       <= '0;
         idx       <= '0;
         snap      <= '0;
         data_q    <= 8'h00;
         rs_q      <= 1'b0;
         en_q      <= 1'b0;
         line_done <= 1'b0;
      end else begin
         line_done <= 1'b0;
         if (state == S_PWRUP) begin
            if (cnt == PWRUP_L) begin
               cnt    <= '0;
               state  <= S_INIT;
               idx    <= '0;
               phase  <= PH_SETUP;
               data_q <= init_cmd(2'd0);
               rs_q   <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            case (phase)
               PH_SETUP:
                  if (cnt == SU_L) begin
                     cnt <= '0; phase <= PH_STROBE; en_q <= 1'b1;
                  end else cnt <= cnt + 1'b1;
               PH_STROBE:
                  if (cnt == EN_L) begin
                     cnt <= '0; phase <= PH_HOLD; en_q <= 1'b0;
                  end else cnt <= cnt + 1'b1;
               PH_HOLD:
                  if (cnt == HOLD_L) begin
                     cnt <= '0; phase <= PH_WAIT;
                  end else cnt <= cnt + 1'b1;
               default: // PH_WAIT: end of wait launches the next byte
                  if (cnt == wait_l) begin
                     cnt   <= '0;
                     phase <= PH_SETUP;
                     case (state)
                        S_INIT:
                           if (idx == 4'd3) begin
                              state  <= S_ADDR;
                              snap   <= din;
                              data_q <= 8'h80;
                              rs_q   <= 1'b0;
                              idx    <= '0;
                           end else begin
                              idx    <= idx + 4'd1;
                              data_q <= init_cmd(idx[1:0] + 2'd1);
                           end
                        S_ADDR: begin
                           state  <= S_CHAR;
                           data_q <= snap[0];
                           rs_q   <= 1'b1;
                           idx    <= '0;
                        end
                        S_CHAR:
                           if (idx == 4'd15) begin
                              // snapshot reloads on the edge that starts ADDR SETUP
                              state     <= S_ADDR;
                              snap      <= din;
                              data_q    <= 8'h80;
                              rs_q      <= 1'b0;
                              line_done <= 1'b1;
                              idx       <= '0;
                           end else begin
                              idx    <= idx + 4'd1;
                              data_q <= snap[idx + 4'd1];
                           end
                        default: state <= S_PWRUP;
                     endcase
                  end else cnt <= cnt + 1'b1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_line_writer.sv
// tb_lcd_line_writer
//   Directed bench for lcd_line_writer with small timing parameters
//   (P = 8 cycles, refresh = 136 cycles). Strobes are captured by a monitor
//   and compared against a table of expected {cycle, data, rs} records.
module tb_lcd_line_writer;

   logic       clk = 1'b0;
   logic       RESET;
   logic [7:0] d [16];
   wire  [7:0] lcd_data;
   logic       lcd_rw, lcd_rs, lcd_en, line_done;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   lcd_line_writer #(
      .T_PWRUP(10), .T_SU(1), .T_EN(2), .T_HOLD(1), .T_CMD(4), .T_CLR(8)
   ) dut (
      .CLOCK_50(clk), .RESET(RESET),
      .d000(d[0]),  .d001(d[1]),  .d002(d[2]),  .d003(d[3]),
      .d004(d[4]),  .d005(d[5]),  .d006(d[6]),  .d007(d[7]),
      .d008(d[8]),  .d009(d[9]),  .d010(d[10]), .d011(d[11]),
      .d012(d[12]), .d013(d[13]), .d014(d[14]), .d015(d[15]),
      .LCD_DATA(lcd_data), .LCD_RW(lcd_rw), .LCD_RS(lcd_rs),
      .LCD_EN(lcd_en), .line_done(line_done)
   );

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       rs;
   } strobe_t;

   strobe_t seen[$];
   int      ld_seen[$];
   strobe_t exp_tab [56];

   // edge count since reset release: after edge k, cyc == k
   always @(posedge clk) begin
      if (RESET) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // strobe / line_done / RW monitor, sampled on the falling edge
   logic en_d = 1'b0;
   int   en_w = 0;
   int   rw_bad = 0;
   always @(negedge clk) begin
      if (RESET) begin
         en_d = 1'b0;
         en_w = 0;
      end else begin
         if (lcd_rw !== 1'b0) rw_bad++;
         if (lcd_en && !en_d) seen.push_back('{cyc, lcd_data, lcd_rs});
         if (lcd_en) en_w++;
         else if (en_d) begin
            chk("en_width", en_w, 2);
            en_w = 0;
         end
         if (line_done) ld_seen.push_back(cyc);
         en_d = lcd_en;
      end
   end

   task automatic run_to(input int c);
      int g = 0;
      while (cyc < c && g < 20000) begin
         @(negedge clk);
         g++;
      end
      chk("run_to_timeout", (cyc >= c), 1);
   endtask

   task automatic cmp_strobes(input string name, input int n);
      chk({name, "_count"}, seen.size(), n);
      for (int i = 0; i < n && i < seen.size(); i++) begin
         tests++;
         if (seen[i].cyc != exp_tab[i].cyc || seen[i].data !== exp_tab[i].data ||
             seen[i].rs !== exp_tab[i].rs) begin
            fails++;
            $display("FAIL %s[%0d]: got cyc=%0d data=%02h rs=%0b expected cyc=%0d data=%02h rs=%0b",
                     name, i, seen[i].cyc, seen[i].data, seen[i].rs,
                     exp_tab[i].cyc, exp_tab[i].data, exp_tab[i].rs);
         end
      end
   endtask

   initial begin
      int k;
      // expected strobes: init, then 0x80 + 16 chars per refresh
      exp_tab[0] = '{11, 8'h38, 1'b0};
      exp_tab[1] = '{19, 8'h0C, 1'b0};
      exp_tab[2] = '{27, 8'h01, 1'b0};
      exp_tab[3] = '{39, 8'h06, 1'b0};
      k = 4;
      for (int r = 0; r < 4; r++) begin
         exp_tab[k] = '{47 + 136*r, 8'h80, 1'b0};
         k++;
         if (r < 3) begin
            for (int i = 0; i < 16; i++) begin
               exp_tab[k] = '{55 + 136*r + 8*i,
                              (r == 2 && i == 5) ? 8'h5A : 8'(8'h41 + i), 1'b1};
               k++;
            end
         end
      end

      for (int i = 0; i < 16; i++) d[i] = 8'(8'h41 + i);
      RESET = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_en",   lcd_en, 0);
      chk("rst_rs",   lcd_rs, 0);
      chk("rst_data", lcd_data, 8'h00);
      chk("rst_rw",   lcd_rw, 0);
      chk("rst_done", line_done, 0);

      RESET = 1'b0;
      run_to(207);          // column 2 of the second refresh
      d[5] = 8'h5A;
      run_to(460);

      cmp_strobes("strobe", 56);
      chk("ld_count", ld_seen.size(), 3);
      if (ld_seen.size() == 3) begin
         chk("ld_first", ld_seen[0], 182);
         chk("ld_gap1",  ld_seen[1] - ld_seen[0], 136);
         chk("ld_gap2",  ld_seen[2] - ld_seen[1], 136);
      end
      chk("rw_zero", rw_bad, 0);

      // reset while column 7 is strobing
      run_to(519);
      chk("mid_en_high", lcd_en, 1);
      RESET = 1'b1;
      #1;
      chk("mid_en_async", lcd_en, 0);
      chk("mid_data", lcd_data, 8'h00);
      seen.delete();
      ld_seen.delete();
      repeat (3) @(negedge clk);
      RESET = 1'b0;
      run_to(50);
      cmp_strobes("reinit", 5);
      chk("reinit_no_ld", ld_seen.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
